phase_frame_sender: RTL

Transmit-side counterpart of the per-channel phase receivers: it collects channel phases into a staging bank and, on command, serializes a frame as a stream of 16-bit `{channel, phase}` words with a strobe. Full mode sends every channel. Delta mode sends only channels written since the last commit. The block sits between the host command decoder and the link/transmitter that feeds the per-channel phase receivers. Downstream backpressure uses `ready`.

---
 rtl/phase_pkg.sv | 28 ++
 rtl/phase_stage_bank.sv | 53 +++++
 rtl/phase_frame_sender.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/phase_pkg.sv
// Shared definitions for the phase link: word layout and sender FSM states,
// common to the transmit and receive sides.
package phase_pkg;

  localparam int PHASE_W = 8;
  localparam int CHAN_W  = 8;

  typedef struct packed {
    logic [CHAN_W-1:0]  channel;
    logic [PHASE_W-1:0] phase;
  } phase_word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } sender_state_t;

  function automatic phase_word_t make_word(
    input logic [CHAN_W-1:0]  channel,
    input logic [PHASE_W-1:0] phase
  );
    phase_word_t word;
    word.channel = channel;
    word.phase   = phase;
    return word;
  endfunction

endpackage

// File: rtl/phase_stage_bank.sv
// Staging registers with per-channel dirty bits. The snapshot view includes a
// same-cycle load so a load coinciding with a snapshot is never lost.
module phase_stage_bank
  import phase_pkg::*;
#(
  parameter int NUM_CHANNELS = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    load_en,
  input  logic [CHAN_W-1:0]                       load_channel,
  input  logic [PHASE_W-1:0]                      load_phase,
  input  logic                                    snap,
  output logic [NUM_CHANNELS-1:0][PHASE_W-1:0]    snap_phase,
  output logic [NUM_CHANNELS-1:0]                 snap_dirty
);

  logic [NUM_CHANNELS-1:0][PHASE_W-1:0] phase_r;
  logic [NUM_CHANNELS-1:0]              dirty_r;
  logic                                 load_hit_s;

  assign load_hit_s = load_en && ({1'b0, load_channel} < 9'(NUM_CHANNELS));

  // Staging contents as they will be after this cycle's load.
  always_comb begin
    snap_phase = phase_r;
    snap_dirty = dirty_r;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (load_hit_s && (load_channel == 8'(i))) begin
        snap_phase[i] = load_phase;
        snap_dirty[i] = 1'b1;
      end else begin
        snap_phase[i] = phase_r[i];
        snap_dirty[i] = dirty_r[i];
      end
    end
  end

  // A snapshot consumes every dirty bit, including one set by a coincident load.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= '0;
      dirty_r <= '0;
    end else if (snap) begin
      phase_r <= snap_phase;
      dirty_r <= '0;
    end else begin
      phase_r <= snap_phase;
      dirty_r <= snap_dirty;
    end
  end

endmodule

// File: rtl/phase_frame_sender.sv
// Phase frame sender: snapshots staged channel phases and serializes full or
// delta frames of {channel, phase} words with ready backpressure.
module phase_frame_sender
  import phase_pkg::*;
#(
  parameter int NUM_CHANNELS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [7:0]  load_channel,
  input  logic [7:0]  load_phase,
  input  logic        commit,
  input  logic        commit_full,
  input  logic        ready,
  output logic [15:0] phase_data,
  output logic        en,
  output logic        busy,
  output logic        pending,
  output logic        frame_done
);

  localparam logic [CHAN_W-1:0] LAST_IDX = 8'(NUM_CHANNELS - 1);

  sender_state_t state_r, state_s;
  logic [CHAN_W-1:0] idx_r, idx_s;
  logic pend_r, pend_s;
  logic pend_full_r, pend_full_s;
  logic done_r, done_s;
  logic snap_s, snap_full_s;

  logic [NUM_CHANNELS-1:0][PHASE_W-1:0] active_r;
  logic [NUM_CHANNELS-1:0]              sel_r;
  logic [NUM_CHANNELS-1:0][PHASE_W-1:0] snap_phase_s;
  logic [NUM_CHANNELS-1:0]              snap_dirty_s;

  logic               cur_sel_s;
  logic [PHASE_W-1:0] cur_phase_s;
  phase_word_t        word_s;

  phase_stage_bank #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_stage (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .load_channel (load_channel),
    .load_phase   (load_phase),
    .snap         (snap_s),
    .snap_phase   (snap_phase_s),
    .snap_dirty   (snap_dirty_s)
  );

  // Select and phase of the channel currently under the scan pointer.
  always_comb begin
    cur_sel_s   = 1'b0;
    cur_phase_s = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (idx_r == 8'(i)) begin
        cur_sel_s   = sel_r[i];
        cur_phase_s = active_r[i];
      end else begin
        cur_sel_s   = cur_sel_s;
        cur_phase_s = cur_phase_s;
      end
    end
  end

  assign word_s     = make_word(idx_r, cur_phase_s);
  assign en         = (state_r == SEND) && cur_sel_s;
  assign phase_data = en ? word_s : 16'h0000;
  assign busy       = (state_r == SEND);
  assign pending    = pend_r;
  assign frame_done = done_r;

  // Next-state logic: snapshot on commit or queued commit, scan, merge commits.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    pend_s      = pend_r;
    pend_full_s = pend_full_r;
    done_s      = 1'b0;
    snap_s      = 1'b0;
    snap_full_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (commit || pend_r) begin
          snap_s      = 1'b1;
          snap_full_s = (commit && commit_full) || (pend_r && pend_full_r);
          idx_s       = '0;
          pend_s      = 1'b0;
          pend_full_s = 1'b0;
          state_s     = SEND;
        end else begin
          idx_s = '0;
        end
      end
      SEND: begin
        if (commit) begin
          pend_s      = 1'b1;
          pend_full_s = pend_full_r || commit_full;
        end else begin
          pend_s = pend_r;
        end
        // Skipped channels advance unconditionally; selected ones wait for ready.
        if (!cur_sel_s || ready) begin
          if (idx_r == LAST_IDX) begin
            state_s = IDLE;
            idx_s   = '0;
            done_s  = 1'b1;
          end else begin
            idx_s = idx_r + 8'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      default: begin
        state_s     = IDLE;
        idx_s       = '0;
        pend_s      = 1'b0;
        pend_full_s = 1'b0;
      end
    endcase
  end

  // FSM, scan pointer and queued-commit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      pend_r      <= 1'b0;
      pend_full_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      pend_r      <= pend_s;
      pend_full_r <= pend_full_s;
      done_r      <= done_s;
    end
  end

  // Active bank and select mask, loaded only at a snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r <= '0;
      sel_r    <= '0;
    end else if (snap_s) begin
      active_r <= snap_phase_s;
      sel_r    <= snap_full_s ? {NUM_CHANNELS{1'b1}} : snap_dirty_s;
    end else begin
      active_r <= active_r;
      sel_r    <= sel_r;
    end
  end

endmodule
